// File: rtl/muldiv_if.sv
// muldiv_if: issue, HI/LO move and status signals between the pipeline and muldiv_ctrl
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic             flush;
    logic             rd_hilo;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] mt_data;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stall_out;
    modport master (
        output start, op, opnd_a, opnd_b, flush, rd_hilo, mthi_we, mtlo_we, mt_data,
        input  hi_out, lo_out, busy, done, div_zero, stall_out
    );
    modport slave (
        input  start, op, opnd_a, opnd_b, flush, rd_hilo, mthi_we, mtlo_we, mt_data,
        output hi_out, lo_out, busy, done, div_zero, stall_out
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
// Magnitudes are processed unsigned; signs are reapplied when the result is written.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb, hi, lo;
    logic               is_div, dz, neg_lo, neg_hi;
    logic               sa, sb, issue, last, commit, ge;
    logic [WIDTH-1:0]   abs_a, abs_b, diff, quo_fix, rem_fix;
    logic [WIDTH:0]     msum, trial;
    logic [2*WIDTH-1:0] prod_fix;
    always_comb begin
        sa       = ~bus.op[0] & bus.opnd_a[WIDTH-1];
        sb       = ~bus.op[0] & bus.opnd_b[WIDTH-1];
        abs_a    = sa ? -bus.opnd_a : bus.opnd_a;
        abs_b    = sb ? -bus.opnd_b : bus.opnd_b;
        issue    = (state == IDLE) & bus.start & ~bus.flush;
        last     = cnt == CW'(WIDTH - 1);
        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        trial    = acc[2*WIDTH-1:WIDTH-1];
        ge       = trial >= {1'b0, opb};
        diff     = trial[WIDTH-1:0] - opb;
        prod_fix = neg_lo ? -acc : acc;
        quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        commit   = (state == DONE) & ~bus.flush & ~dz;
        state_n  = state;
        if (state == IDLE) begin
            if (issue)
                state_n = ~bus.op[1] ? MUL : (bus.opnd_b == '0 ? DONE : DIV);
        end else if (bus.flush || state == DONE)
            state_n = IDLE;
        else if (last)
            state_n = DONE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (issue) begin
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
                opb    <= bus.op[1] ? abs_b : abs_a;
                is_div <= bus.op[1];
                dz     <= bus.op[1] & (bus.opnd_b == '0);
                neg_lo <= sa ^ sb;
                neg_hi <= sa;
            end else if (state == MUL) begin
                cnt <= cnt + 1'b1;
                acc <= {msum, acc[WIDTH-1:1]};
            end else if (state == DIV) begin
                cnt <= cnt + 1'b1;
                acc <= ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
            end
            // MTHI/MTLO land before a same-cycle start; the op overwrites later
            if (commit)
                {hi, lo} <= is_div ? {rem_fix, quo_fix} : prod_fix;
            else if (state == IDLE) begin
                if (bus.mthi_we) hi <= bus.mt_data;
                if (bus.mtlo_we) lo <= bus.mt_data;
            end
        end
    end
    assign bus.hi_out    = hi;
    assign bus.lo_out    = lo;
    assign bus.busy      = state != IDLE;
    assign bus.done      = (state == DONE) & ~bus.flush;
    assign bus.div_zero  = bus.done & dz;
    assign bus.stall_out = bus.busy & ~bus.flush & (bus.start | bus.rd_hilo | bus.mthi_we | bus.mtlo_we);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, hand sequences and random ops against an arithmetic model
module tb_muldiv_ctrl;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    muldiv_if #(.WIDTH(32)) bus();
    muldiv_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;
    vec_t vecs[5];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (o)
            2'd0:    return sa * sb;
            2'd1:    return ua * ub;
            2'd2:    return {32'(sa % sb), 32'(sa / sb)};
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction
    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        bus.mthi_we = h;
        bus.mtlo_we = l;
        bus.mt_data = d;
        @(negedge clk);
        bus.mthi_we = 0;
        bus.mtlo_we = 0;
        if (h) m_hi = d;
        if (l) m_lo = d;
    endtask
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit z);
        int nb = 0, nd = 0, nz = 0;
        @(negedge clk);
        bus.start = 1;
        bus.op = o;
        bus.opnd_a = a;
        bus.opnd_b = b;
        @(negedge clk);
        bus.start = 0;
        for (int i = 0; i < 100 && bus.busy; i++) begin
            nb++;
            nd += int'(bus.done);
            nz += int'(bus.div_zero);
            @(negedge clk);
        end
        if (!z) begin
            m_hi = eh;
            m_lo = el;
        end
        chk({nm, " busy_cycles"}, nb, z ? 1 : 33);
        chk({nm, " done_pulses"}, nd, 1);
        chk({nm, " dz_pulses"}, nz, z ? 1 : 0);
        chk({nm, " hi"}, bus.hi_out, m_hi);
        chk({nm, " lo"}, bus.lo_out, m_lo);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] r;
        int nd;
        {bus.start, bus.op, bus.opnd_a, bus.opnd_b, bus.flush} = '0;
        {bus.rd_hilo, bus.mthi_we, bus.mtlo_we, bus.mt_data} = '0;
        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        repeat (2) @(negedge clk);
        chk("reset hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        chk("reset flags", {bus.busy, bus.done, bus.div_zero, bus.stall_out}, 64'd0);
        rst = 0;
        mt_write(1, 0, 32'hABCD);
        chk("mthi hi", bus.hi_out, 32'hABCD);
        chk("mthi lo", bus.lo_out, 32'd0);
        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 0);
        mt_write(1, 0, 32'h11);
        mt_write(0, 1, 32'h22);
        run_op("divu_by_zero", 2'd3, 32'd100, 32'd0, 32'h11, 32'h22, 1);
        // flush mid-multiply
        @(negedge clk);
        bus.start = 1;
        bus.op = 2'd0;
        bus.opnd_a = 5;
        bus.opnd_b = 5;
        @(negedge clk);
        bus.start = 0;
        nd = 0;
        for (int i = 0; i < 9; i++) begin
            nd += int'(bus.done);
            @(negedge clk);
        end
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        chk("flush busy", bus.busy, 0);
        chk("flush hilo", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
        chk("flush done", nd, 0);
        // stall requests while busy
        @(negedge clk);
        bus.start = 1;
        bus.op = 2'd1;
        bus.opnd_a = 6;
        bus.opnd_b = 7;
        @(negedge clk);
        bus.start = 0;
        #1 chk("stall none", bus.stall_out, 0);
        bus.rd_hilo = 1;
        #1 chk("stall rd_hilo", bus.stall_out, 1);
        @(negedge clk);
        bus.rd_hilo = 0;
        bus.mthi_we = 1;
        bus.mt_data = 32'hDEAD;
        #1 chk("stall mthi", bus.stall_out, 1);
        @(negedge clk);
        bus.mthi_we = 0;
        bus.start = 1;
        bus.op = 2'd0;
        bus.opnd_a = 1;
        bus.opnd_b = 1;
        #1 chk("stall start", bus.stall_out, 1);
        @(negedge clk);
        bus.start = 0;
        chk("stall hilo held", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
        for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
        m_hi = 0;
        m_lo = 42;
        chk("stall result", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            if ($urandom_range(0, 5) == 0) a = -a;
            if (b == 0) b = 1;
            r = ref_res(o, a, b);
            run_op($sformatf("rand%0d op%0d", i, o), o, a, b, r[63:32], r[31:0], 0);
        end
        // asynchronous reset in the middle of a divide
        mt_write(1, 1, 32'h5A5A);
        @(negedge clk);
        bus.start = 1;
        bus.op = 2'd2;
        bus.opnd_a = 100;
        bus.opnd_b = 7;
        @(negedge clk);
        bus.start = 0;
        repeat (5) @(negedge clk);
        bus.rd_hilo = 1;
        #1 rst = 1;
        #1 chk("async rst hilo", {bus.hi_out, bus.lo_out}, 64'd0);
        chk("async rst flags", {bus.busy, bus.done, bus.div_zero, bus.stall_out}, 64'd0);
        @(negedge clk);
        bus.rd_hilo = 0;
        rst = 0;
        @(negedge clk);
        chk("post rst idle", bus.busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the pipelined MIPS core; serves MULT, MULTU, DIV and DIVU, and owns the HI/LO register pair.
- Sits beside the EX stage. The control unit decodes the op and issues start; this block runs a 32-step shift-add or restoring-divide datapath.
- Raises stall_out to freeze the front of the pipeline while any later instruction needs HI/LO or the unit.
- One clock; reset is asynchronous and active-high (clk, rst).

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; HI/LO are each WIDTH bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  EX-stage mul/div issue strobe
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
opnd_a  input  WIDTH  rs value (multiplicand / dividend)
opnd_b  input  WIDTH  rt value (multiplier / divisor)
flush  input  1  squash in-flight op (EX flush)
rd_hilo  input  1  ID-stage instruction reads HI or LO (MFHI/MFLO)
mthi_we  input  1  write HI from mt_data
mtlo_we  input  1  write LO from mt_data
mt_data  input  WIDTH  MTHI/MTLO data
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register
busy  output  1  operation in progress (states MUL, DIV, DONE)
done  output  1  one-cycle pulse in DONE state
div_zero  output  1  one-cycle pulse: divide by zero detected
stall_out  output  1  pipeline stall request

Behaviour:
- Reset: state IDLE, counter 0, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, stall_out=0. Reset mid-operation aborts immediately; no HI/LO write.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - Capture the operand magnitudes (two's-complement abs for MULT/DIV) and the result signs.
  - Result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - Counter=0. Go to MUL (op[1]=0) or DIV (op[1]=1).
- DIV with opnd_b==0: go directly to DONE with a zero-divide flag. div_zero pulses in DONE, HI/LO are not written, and busy lasts 1 cycle.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator.
- DIV: one restoring step per cycle, shifting the remainder and setting one quotient bit.
- In MUL and DIV, the counter increments each cycle; after the WIDTH-th step, go to DONE.
- Latency: start sampled at edge E0. The MUL/DIV state spans E0..E0+WIDTH. DONE is entered at edge E0+WIDTH and lasts one cycle. HI/LO update at edge E0+WIDTH+1, which returns to IDLE. busy is high for WIDTH+1 cycles.
- DONE result write, with sign fix applied (negate if the sign bit is set, mod 2^WIDTH):
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- flush=1 while in MUL, DIV or DONE: return to IDLE at the next edge; HI/LO unchanged; done/div_zero not pulsed.
- flush=1 with start=1 in IDLE: start is ignored.
- start while busy: ignored, and stall_out=1 that cycle.
- MTHI/MTLO:
  - In IDLE, write at the edge.
  - If busy, the write is blocked and stall_out=1.
  - mthi_we and mtlo_we together write both registers.
  - mt* together with start in IDLE: mt* writes first at that edge; the started op overwrites HI/LO on completion.
- stall_out is combinational: busy & (start | rd_hilo | mthi_we | mtlo_we). It is 0 when flush=1.
- hi_out/lo_out are registered. An MFHI issued the cycle after DONE reads the new value.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 busy cycles, HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly once.
- MULT -3 (0xFFFFFFFD) * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/0 with HI=0x11, LO=0x22 -> busy 1 cycle, div_zero pulse, HI/LO stay 0x11/0x22.
- MULT 5*5 then flush at cycle 10 -> IDLE next cycle, HI/LO unchanged, no done; rst asserted mid-DIV -> all outputs 0 asynchronously.
- rd_hilo, mthi_we and a second start each asserted during busy -> stall_out=1 each cycle, no HI/LO change until DONE. mthi_we with 0xABCD in IDLE -> HI=0xABCD next cycle.
